// File: rtl/pipeline_controller_pkg.sv
// Shared types for the microRISC pipeline controller:
// FSM state encodings and the per-stage control bundle.
package pipeline_controller_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DWAIT  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
  } stage_ctl_t;

  localparam stage_ctl_t CTL_FREEZE = stage_ctl_t'(7'b000_0000);
  localparam stage_ctl_t CTL_RESET  = stage_ctl_t'(7'b001_0100);
  localparam stage_ctl_t CTL_ADV    = stage_ctl_t'(7'b110_1011);
  localparam stage_ctl_t CTL_FLUSH  = stage_ctl_t'(7'b111_1111);
  localparam stage_ctl_t CTL_STALL  = stage_ctl_t'(7'b000_1111);
  localparam stage_ctl_t CTL_IMISS  = stage_ctl_t'(7'b011_1011);
  localparam stage_ctl_t CTL_RETIRE = stage_ctl_t'(7'b000_0001);

endpackage

// File: rtl/pipeline_controller_sat.sv
// sat_counter: up-counter that sticks at all-ones.
// Ports: clk_i, clr_i (sync clear, wins), en_i, q_o.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en_i && (q_q != '1)) q_d = q_q + W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline sequencer: hazards, dmem wait, watchdog, halt -> stage enables/flushes.
// Ports: clk, rst (sync, high), hazard/mem/halt inputs, stage controls, status, perf counters.
module pipeline_controller
  import pipeline_controller_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hz_stall,
  input  logic             hz_flush,
  input  logic             imem_ready,
  input  logic             mem_access,
  input  logic             dmem_ready,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);

  state_e          state_q, state_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic            mto_q, mto_d;
  stage_ctl_t      ctl, ctl_o;
  logic            run_eval, mem_ok;
  logic            stall_inc, flush_inc;

  always_comb begin
    state_d   = state_q;
    wd_d      = wd_q;
    mto_d     = mto_q;
    ctl       = CTL_FREEZE;
    run_eval  = 1'b0;
    mem_ok    = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        run_eval = 1'b1;
        mem_ok   = !(mem_access && !dmem_ready);
      end
      ST_DWAIT: begin
        if (dmem_ready) begin
          run_eval = 1'b1;
          mem_ok   = 1'b1;
        end else if (wd_q == TO_MAX) begin
          state_d = ST_HALTED;
          mto_d   = 1'b1;
          wd_d    = '0;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      ST_HALTED: begin
        if (resume) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    if (run_eval) begin
      if (!mem_ok) begin
        state_d = ST_DWAIT;
        wd_d    = TO_W'(1);
      end else begin
        state_d = ST_RUN;
        wd_d    = '0;
        if (halt_req) begin
          ctl     = CTL_RETIRE;
          state_d = ST_HALTED;
        end else if (hz_flush) begin
          // a coincident stall is moot: its instruction is squashed
          ctl       = CTL_FLUSH;
          flush_inc = 1'b1;
        end else if (hz_stall) begin
          ctl       = CTL_STALL;
          stall_inc = (state_q == ST_RUN);
        end else if (!imem_ready) begin
          ctl       = CTL_IMISS;
          stall_inc = (state_q == ST_RUN);
        end else begin
          ctl = CTL_ADV;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      wd_q    <= '0;
      mto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      mto_q   <= mto_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk),
    .clr_i (rst),
    .en_i  (stall_inc),
    .q_o   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk),
    .clr_i (rst),
    .en_i  (flush_inc),
    .q_o   (flush_cnt)
  );

  assign ctl_o       = rst ? CTL_RESET : ctl;
  assign pc_en       = ctl_o.pc_en;
  assign if_id_en    = ctl_o.if_id_en;
  assign if_id_flush = ctl_o.if_id_flush;
  assign id_ex_en    = ctl_o.id_ex_en;
  assign id_ex_flush = ctl_o.id_ex_flush;
  assign ex_mem_en   = ctl_o.ex_mem_en;
  assign mem_wb_en   = ctl_o.mem_wb_en;
  assign halted      = !rst && (state_q == ST_HALTED);
  assign mem_timeout = mto_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller (CNT_W=2, TIMEOUT=4).
// Inputs change 1ns after posedge; outputs checked on negedge.
module tb_pipeline_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, hz_stall, hz_flush, imem_ready;
  logic mem_access, dmem_ready, halt_req, resume;
  logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic ex_mem_en, mem_wb_en, halted, mem_timeout;
  logic [1:0] stall_cnt, flush_cnt;

  pipeline_controller #(.CNT_W(2), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .hz_stall(hz_stall), .hz_flush(hz_flush),
    .imem_ready(imem_ready), .mem_access(mem_access),
    .dmem_ready(dmem_ready), .halt_req(halt_req), .resume(resume),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .halted(halted), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  logic [12:0] obs;
  assign obs = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                ex_mem_en, mem_wb_en, halted, mem_timeout,
                stall_cnt, flush_cnt};

  // {pc,ifen,iff,idxen,idxf,exm,mwb,halted,mto}
  localparam logic [8:0] C_RST   = 9'b001010000;
  localparam logic [8:0] C_EN    = 9'b110101100;
  localparam logic [8:0] C_OFF   = 9'b000000000;
  localparam logic [8:0] C_STALL = 9'b000111100;
  localparam logic [8:0] C_FLUSH = 9'b111111100;
  localparam logic [8:0] C_IMISS = 9'b011101100;
  localparam logic [8:0] C_HREQ  = 9'b000000100;
  localparam logic [8:0] C_HALT  = 9'b000000010;
  localparam logic [8:0] C_HTO   = 9'b000000011;
  localparam logic [8:0] C_ENTO  = 9'b110101101;

  // {rst,stall,flush,imem,macc,dready,halt,resume}
  localparam logic [7:0] I_RST   = 8'b10010000;
  localparam logic [7:0] I_IDLE  = 8'b00010000;
  localparam logic [7:0] I_STALL = 8'b01010000;
  localparam logic [7:0] I_FLUSH = 8'b00110000;
  localparam logic [7:0] I_SF    = 8'b01110000;
  localparam logic [7:0] I_MISS  = 8'b00000000;
  localparam logic [7:0] I_MWAIT = 8'b00011000;
  localparam logic [7:0] I_MWFL  = 8'b00111000;
  localparam logic [7:0] I_MRDY  = 8'b00011100;
  localparam logic [7:0] I_MRDST = 8'b01011100;
  localparam logic [7:0] I_HLTFL = 8'b00110010;
  localparam logic [7:0] I_RESUM = 8'b00010001;

  logic [12:0] sb[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic drive(input logic [7:0] v, input logic [12:0] e);
    @(posedge clk);
    #1;
    {rst, hz_stall, hz_flush, imem_ready,
     mem_access, dmem_ready, halt_req, resume} = v;
    sb.push_back(e);
  endtask

  task automatic reset_dut();
    @(posedge clk);
    #1;
    {rst, hz_stall, hz_flush, imem_ready,
     mem_access, dmem_ready, halt_req, resume} = I_RST;
    @(posedge clk);
  endtask

  task automatic test_reset();
    logic [7:0]  st [3] = '{I_RST, I_RST, I_IDLE};
    logic [12:0] ex [3] = '{{C_RST, 4'd0}, {C_RST, 4'd0}, {C_EN, 4'd0}};
    logic [12:0] e;
    for (int i = 0; i < 3; i++) begin
      drive(st[i], ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL reset[%0d]: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_stall();
    logic [7:0]  st [2] = '{I_STALL, I_IDLE};
    logic [12:0] ex [2] = '{{C_STALL, 2'd0, 2'd0}, {C_EN, 2'd1, 2'd0}};
    logic [12:0] e;
    reset_dut();
    for (int i = 0; i < 2; i++) begin
      drive(st[i], ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL stall[%0d]: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_stall_flush();
    logic [7:0]  st [2] = '{I_SF, I_IDLE};
    logic [12:0] ex [2] = '{{C_FLUSH, 2'd0, 2'd0}, {C_EN, 2'd0, 2'd1}};
    logic [12:0] e;
    reset_dut();
    for (int i = 0; i < 2; i++) begin
      drive(st[i], ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL stall_flush[%0d]: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_imiss();
    logic [7:0]  st [2] = '{I_MISS, I_IDLE};
    logic [12:0] ex [2] = '{{C_IMISS, 2'd0, 2'd0}, {C_EN, 2'd1, 2'd0}};
    logic [12:0] e;
    reset_dut();
    for (int i = 0; i < 2; i++) begin
      drive(st[i], ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL imiss[%0d]: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_dwait();
    logic [7:0]  st [9] = '{I_MWAIT, I_MWAIT, I_MWFL, I_MWAIT, I_MRDY,
                            I_IDLE, I_MWAIT, I_MRDST, I_IDLE};
    logic [12:0] ex [9] = '{{C_OFF, 4'd0}, {C_OFF, 4'd0}, {C_OFF, 4'd0},
                            {C_OFF, 4'd0}, {C_EN, 4'd0}, {C_EN, 4'd0},
                            {C_OFF, 4'd0}, {C_STALL, 4'd0}, {C_EN, 4'd0}};
    logic [12:0] e;
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      drive(st[i], ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL dwait[%0d]: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0]  st [8] = '{I_MWAIT, I_MWAIT, I_MWAIT, I_MWAIT, I_MWAIT,
                            I_IDLE, I_RESUM, I_IDLE};
    logic [12:0] ex [8] = '{{C_OFF, 4'd0}, {C_OFF, 4'd0}, {C_OFF, 4'd0},
                            {C_OFF, 4'd0}, {C_OFF, 4'd0}, {C_HTO, 4'd0},
                            {C_HTO, 4'd0}, {C_ENTO, 4'd0}};
    logic [12:0] e;
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      drive(st[i], ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL timeout[%0d]: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_halt();
    logic [7:0]  st [7] = '{I_HLTFL, I_FLUSH, I_FLUSH, I_RST,
                            I_IDLE, I_FLUSH, I_IDLE};
    logic [12:0] ex [7] = '{{C_HREQ, 4'd0}, {C_HALT, 4'd0}, {C_HALT, 4'd0},
                            {C_RST, 4'd0}, {C_EN, 4'd0}, {C_FLUSH, 4'd0},
                            {C_EN, 2'd0, 2'd1}};
    logic [12:0] e;
    reset_dut();
    for (int i = 0; i < 7; i++) begin
      drive(st[i], ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL halt[%0d]: got %b want %b", i, obs, e);
      end
    end
  endtask

  task automatic test_saturate();
    logic [7:0]  st [6] = '{I_STALL, I_STALL, I_STALL, I_STALL, I_STALL,
                            I_IDLE};
    logic [12:0] ex [6] = '{{C_STALL, 2'd0, 2'd0}, {C_STALL, 2'd1, 2'd0},
                            {C_STALL, 2'd2, 2'd0}, {C_STALL, 2'd3, 2'd0},
                            {C_STALL, 2'd3, 2'd0}, {C_EN, 2'd3, 2'd0}};
    logic [12:0] e;
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      drive(st[i], ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL saturate[%0d]: got %b want %b", i, obs, e);
      end
    end
  endtask

  initial begin
    {rst, hz_stall, hz_flush, imem_ready,
     mem_access, dmem_ready, halt_req, resume} = I_RST;
    test_reset();
    test_stall();
    test_stall_flush();
    test_imiss();
    test_dwait();
    test_timeout();
    test_halt();
    test_saturate();
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL sim_time: limit reached, bench did not complete");
    $fatal(1);
  end

endmodule
